// File: rtl/mem_stage.sv
// Memory stage: registers the execute result, runs loads/stores on the dm req/gnt/rvalid bus, retires to writeback.
// Optional misaligned-access suppression is enabled with `define MEM_MISALIGN_CHECK_EN.
package ex_stage_pkg;

    typedef struct packed {
        logic        rf_en;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic        is_jal;
        logic        dm_rd_en;
        logic        dm_wr_en;
        logic [2:0]  mem_size;   // funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
        logic [31:0] opr_res;
        logic [31:0] opr_b;
        logic [31:0] pc4;
    } ex_stage_out_t;

    typedef struct packed {
        logic        rf_en;
        logic [4:0]  rd;
        logic [31:0] opr_res;
        logic [31:0] pc4;
        logic        is_jal;
    } ex_stage_in_frm_mem_t;

endpackage

module mem_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 ex_valid,
    input  ex_stage_out_t        ex_in,
    output logic                 mem_ready,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [31:0]          dm_addr,
    output logic [3:0]           dm_be,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_gnt,
    input  logic                 dm_rvalid,
    input  logic [31:0]          dm_rdata,
    output ex_stage_in_frm_mem_t fwd_out,
    output logic                 wb_valid,
    output logic                 wb_rf_en,
    output logic [4:0]           wb_rd,
    output logic [31:0]          wb_opr_res,
    output logic [31:0]          wb_load_data,
    output logic [31:0]          wb_pc4,
    output logic [1:0]           wb_sel,
    output logic                 mis_align,
    output logic                 bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    localparam logic [7:0] TMO_LAST = 8'(DM_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          m_valid_q;
    ex_stage_out_t m_q;
    logic [7:0]    tmo_q, tmo_d;

    logic          wb_valid_q, wb_rf_en_q, bus_err_q;
    logic [4:0]    wb_rd_q;
    logic [31:0]   wb_opr_res_q, wb_load_data_q, wb_pc4_q;
    logic [1:0]    wb_sel_q;

    logic          mis_m, mis_ex, acc_done, tmo_hit, completing, issue_ex;
    logic [31:0]   load_fmt;

    function automatic logic [31:0] fmt_load(input logic [2:0] sz, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

`ifdef MEM_MISALIGN_CHECK_EN
    function automatic logic misaligned(input ex_stage_out_t e);
        if (!(e.dm_rd_en || e.dm_wr_en)) return 1'b0;
        case (e.mem_size[1:0])
            2'b01:   return e.opr_res[0];
            2'b10:   return e.opr_res[1:0] != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    assign mis_m  = m_valid_q && misaligned(m_q);
    assign mis_ex = misaligned(ex_in);
`else
    assign mis_m  = 1'b0;
    assign mis_ex = 1'b0;
`endif

    // Completion: a store finishes on grant, a load on rvalid (possibly in the grant cycle).
    assign acc_done = (state_q == S_REQ && dm_gnt && (m_q.dm_wr_en || dm_rvalid)) ||
                      (state_q == S_WAIT && dm_rvalid);
    assign tmo_hit  = (state_q != S_IDLE) && !acc_done && (tmo_q == TMO_LAST);
    assign completing = m_valid_q &&
                        (!(m_q.dm_rd_en || m_q.dm_wr_en) || mis_m || acc_done || tmo_hit);
    assign mem_ready = !m_valid_q || completing;
    assign issue_ex  = ex_valid && (ex_in.dm_rd_en || ex_in.dm_wr_en) && !mis_ex;
    assign load_fmt  = fmt_load(m_q.mem_size, m_q.opr_res[1:0], dm_rdata);

    // The request starts at the same edge that loads MEM, so it is on the bus in that cycle.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        if (mem_ready) begin
            state_d = issue_ex ? S_REQ : S_IDLE;
            tmo_d   = 8'd0;
        end else begin
            if (state_q == S_REQ && dm_gnt) state_d = S_WAIT;
            if (state_q != S_IDLE)          tmo_d   = tmo_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'd0;
        dm_be    = 4'h0;
        dm_wdata = 32'd0;
        if (state_q == S_REQ) begin
            dm_req  = 1'b1;
            dm_we   = m_q.dm_wr_en;
            dm_addr = {m_q.opr_res[31:2], 2'b00};
            dm_be   = 4'hF;
            if (m_q.dm_wr_en) begin
                case (m_q.mem_size[1:0])
                    2'b00: begin
                        dm_be    = 4'b0001 << m_q.opr_res[1:0];
                        dm_wdata = {4{m_q.opr_b[7:0]}};
                    end
                    2'b01: begin
                        dm_be    = 4'b0011 << {m_q.opr_res[1], 1'b0};
                        dm_wdata = {2{m_q.opr_b[15:0]}};
                    end
                    default: dm_wdata = m_q.opr_b;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_valid_q <= 1'b0;
            m_q       <= '0;
        end else if (mem_ready) begin
            m_valid_q <= ex_valid;
            m_q       <= ex_in;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wb_valid_q     <= 1'b0;
            wb_rf_en_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_opr_res_q   <= 32'd0;
            wb_load_data_q <= 32'd0;
            wb_pc4_q       <= 32'd0;
            wb_sel_q       <= 2'd0;
            bus_err_q      <= 1'b0;
        end else begin
            wb_valid_q <= completing;
            bus_err_q  <= completing && tmo_hit;
            if (completing) begin
                wb_rf_en_q     <= m_q.rf_en && !mis_m && !tmo_hit;
                wb_rd_q        <= m_q.rd;
                wb_opr_res_q   <= m_q.opr_res;
                wb_load_data_q <= (m_q.dm_rd_en && acc_done) ? load_fmt : 32'd0;
                wb_pc4_q       <= m_q.pc4;
                wb_sel_q       <= m_q.wb_sel;
            end
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic mis_align_q;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) mis_align_q <= 1'b0;
        else         mis_align_q <= completing && mis_m;
    end
    assign mis_align = mis_align_q;
`else
    assign mis_align = 1'b0;
`endif

    // Loads are not bypassed from here; their data only exists once writeback has it.
    always_comb begin
        fwd_out.rf_en   = m_valid_q && m_q.rf_en && !m_q.dm_rd_en;
        fwd_out.rd      = m_q.rd;
        fwd_out.opr_res = m_q.opr_res;
        fwd_out.pc4     = m_q.pc4;
        fwd_out.is_jal  = m_q.is_jal;
    end

    assign wb_valid     = wb_valid_q;
    assign wb_rf_en     = wb_rf_en_q;
    assign wb_rd        = wb_rd_q;
    assign wb_opr_res   = wb_opr_res_q;
    assign wb_load_data = wb_load_data_q;
    assign wb_pc4       = wb_pc4_q;
    assign wb_sel       = wb_sel_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: drives the execute side and the data-memory bus by hand,
// and checks writeback results against a queue of expected records.
module tb_mem_stage;
    import ex_stage_pkg::*;

    localparam int unsigned TMO = 16;

    logic                 clk = 1'b0;
    logic                 arst_n = 1'b0;
    logic                 ex_valid = 1'b0;
    ex_stage_out_t        ex_in = '0;
    logic                 mem_ready, dm_req, dm_we;
    logic [31:0]          dm_addr, dm_wdata;
    logic [3:0]           dm_be;
    logic                 dm_gnt = 1'b0, dm_rvalid = 1'b0;
    logic [31:0]          dm_rdata = 32'd0;
    ex_stage_in_frm_mem_t fwd_out;
    logic                 wb_valid, wb_rf_en, mis_align, bus_err;
    logic [4:0]           wb_rd;
    logic [31:0]          wb_opr_res, wb_load_data, wb_pc4;
    logic [1:0]           wb_sel;

    mem_stage #(.DM_TIMEOUT(TMO)) dut (
        .clk(clk), .arst_n(arst_n), .ex_valid(ex_valid), .ex_in(ex_in),
        .mem_ready(mem_ready), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .fwd_out(fwd_out), .wb_valid(wb_valid), .wb_rf_en(wb_rf_en),
        .wb_rd(wb_rd), .wb_opr_res(wb_opr_res), .wb_load_data(wb_load_data),
        .wb_pc4(wb_pc4), .wb_sel(wb_sel), .mis_align(mis_align), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rf_en;
        logic [31:0] res;
        logic [31:0] ld;
        logic [31:0] pc4;
        logic [1:0]  sel;
    } wb_t;

    wb_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ex_stage_out_t mk(input logic rd_en, input logic wr_en,
                                         input logic [2:0] sz, input logic [31:0] res,
                                         input logic [31:0] b, input logic [4:0] rd,
                                         input logic rf_en);
        ex_stage_out_t e;
        e          = '0;
        e.dm_rd_en = rd_en;
        e.dm_wr_en = wr_en;
        e.mem_size = sz;
        e.opr_res  = res;
        e.opr_b    = b;
        e.rd       = rd;
        e.rf_en    = rf_en;
        e.pc4      = res ^ 32'hA5A5_0000;
        e.wb_sel   = rd_en ? 2'd1 : 2'd0;
        return e;
    endfunction

    function automatic wb_t wbx(input ex_stage_out_t e, input logic [31:0] ld, input logic rf);
        return '{rd: e.rd, rf_en: rf, res: e.opr_res, ld: ld, pc4: e.pc4, sel: e.wb_sel};
    endfunction

    // Writeback scoreboard: every retire must match the oldest pending expectation.
    always @(negedge clk) begin
        if (arst_n && wb_valid) begin
            chk("wb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                chk("wb_payload", {wb_rd, wb_rf_en, wb_opr_res, wb_load_data, wb_pc4, wb_sel},
                    exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input ex_stage_out_t e);
        ex_in    = e;
        ex_valid = 1'b1;
        @(negedge clk);
        chk("issue_ready", mem_ready, 1);
        edge1();
        ex_valid = 1'b0;
    endtask

    task automatic load0(input ex_stage_out_t e, input logic [31:0] rdata, input logic [31:0] ld);
        exp_q.push_back(wbx(e, ld, 1'b1));
        issue(e);
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = rdata;
        @(negedge clk);
        chk("ld0_ready", mem_ready, 1);
        chk("ld0_be", dm_be, 4'hF);
        chk("ld0_we", dm_we, 0);
        edge1();
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
    endtask

    initial begin
        ex_stage_out_t e, e2;
        int cyc;
        logic done;

        // Reset state
        @(negedge clk);
        chk("rst_ready", mem_ready, 1);
        chk("rst_req", dm_req, 0);
        chk("rst_be", dm_be, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_buserr", bus_err, 0);
        chk("rst_misalign", mis_align, 0);
        chk("rst_fwd", fwd_out, 0);
        #1 arst_n = 1'b1;
        edge1();

        // Non-memory op: retires one edge later, no stall, bypass visible while in MEM
        e = mk(0, 0, 3'b010, 32'h1234, 32'h0, 5'd5, 1'b1);
        exp_q.push_back(wbx(e, 32'd0, 1'b1));
        issue(e);
        @(negedge clk);
        chk("add_fwd_rd", fwd_out.rd, 5);
        chk("add_fwd_rf", fwd_out.rf_en, 1);
        chk("add_fwd_res", fwd_out.opr_res, 32'h1234);
        chk("add_ready", mem_ready, 1);
        chk("add_noreq", dm_req, 0);
        edge1();
        @(negedge clk);
        chk("add_wbv", wb_valid, 1);
        edge1();

        // SB with grant delayed three cycles
        e = mk(0, 1, 3'b000, 32'h1003, 32'hAB, 5'd0, 1'b0);
        exp_q.push_back(wbx(e, 32'd0, 1'b0));
        issue(e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sb_stall", mem_ready, 0);
            chk("sb_req", dm_req, 1);
            chk("sb_we", dm_we, 1);
            chk("sb_addr", dm_addr, 32'h1000);
            chk("sb_be", dm_be, 4'b1000);
            chk("sb_wdata", dm_wdata, 32'hABABABAB);
            edge1();
        end
        dm_gnt = 1'b1;
        @(negedge clk);
        chk("sb_gnt_ready", mem_ready, 1);
        edge1();
        dm_gnt = 1'b0;
        @(negedge clk);
        chk("sb_idle", dm_req, 0);
        chk("sb_wbv", wb_valid, 1);
        edge1();

        // Back-to-back SH then SW, both granted immediately
        e  = mk(0, 1, 3'b001, 32'h1002, 32'h12345678, 5'd0, 1'b0);
        e2 = mk(0, 1, 3'b010, 32'h1008, 32'hCAFEF00D, 5'd0, 1'b0);
        exp_q.push_back(wbx(e, 32'd0, 1'b0));
        exp_q.push_back(wbx(e2, 32'd0, 1'b0));
        issue(e);
        ex_in = e2; ex_valid = 1'b1; dm_gnt = 1'b1;
        @(negedge clk);
        chk("sh_be", dm_be, 4'b1100);
        chk("sh_wdata", dm_wdata, 32'h56785678);
        chk("sh_addr", dm_addr, 32'h1000);
        chk("sh_ready", mem_ready, 1);
        edge1();
        ex_valid = 1'b0;
        @(negedge clk);
        chk("b2b_req", dm_req, 1);
        chk("sw_addr", dm_addr, 32'h1008);
        chk("sw_be", dm_be, 4'hF);
        chk("sw_wdata", dm_wdata, 32'hCAFEF00D);
        edge1();
        dm_gnt = 1'b0;
        @(negedge clk);
        chk("sw_idle", dm_req, 0);
        edge1();

        // Zero-wait loads with lane selection and extension
        load0(mk(1, 0, 3'b000, 32'h2002, 32'h0, 5'd1, 1'b1), 32'h00800000, 32'hFFFFFF80);
        load0(mk(1, 0, 3'b100, 32'h2002, 32'h0, 5'd2, 1'b1), 32'h00800000, 32'h00000080);
        load0(mk(1, 0, 3'b001, 32'h2002, 32'h0, 5'd3, 1'b1), 32'h80010000, 32'hFFFF8001);
        load0(mk(1, 0, 3'b101, 32'h2000, 32'h0, 5'd4, 1'b1), 32'h00008001, 32'h00008001);

        // LW: grant first cycle, rvalid one cycle later -> exactly one stall
        e = mk(1, 0, 3'b010, 32'h2004, 32'h0, 5'd7, 1'b1);
        exp_q.push_back(wbx(e, 32'hDEADBEEF, 1'b1));
        issue(e);
        dm_gnt = 1'b1;
        @(negedge clk);
        chk("lw_req", dm_req, 1);
        chk("lw_stall_c1", mem_ready, 0);
        edge1();
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("lw_wait_noreq", dm_req, 0);
        chk("lw_ready_c2", mem_ready, 1);
        edge1();
        dm_rvalid = 1'b0;
        @(negedge clk);
        chk("lw_wbv", wb_valid, 1);
        edge1();

        // LH at an odd address
        e = mk(1, 0, 3'b001, 32'h3001, 32'h0, 5'd9, 1'b1);
`ifdef MEM_MISALIGN_CHECK_EN
        exp_q.push_back(wbx(e, 32'd0, 1'b0));
        issue(e);
        @(negedge clk);
        chk("ma_noreq", dm_req, 0);
        chk("ma_ready", mem_ready, 1);
        edge1();
        @(negedge clk);
        chk("ma_pulse", mis_align, 1);
        edge1();
        @(negedge clk);
        chk("ma_pulse_end", mis_align, 0);
        edge1();
`else
        exp_q.push_back(wbx(e, 32'hFFFF8001, 1'b1));
        issue(e);
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h00008001;
        @(negedge clk);
        chk("ma_req", dm_req, 1);
        chk("ma_addr", dm_addr, 32'h3000);
        edge1();
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        @(negedge clk);
        chk("ma_none", mis_align, 0);
        edge1();
`endif

        // LW whose rvalid never comes: abort after the timeout
        e = mk(1, 0, 3'b010, 32'h4000, 32'h0, 5'd11, 1'b1);
        exp_q.push_back(wbx(e, 32'd0, 1'b0));
        issue(e);
        dm_gnt = 1'b1;
        cyc = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (mem_ready) done = 1'b1;
            edge1();
            dm_gnt = 1'b0;
        end
        chk("tmo_done", done, 1);
        chk("tmo_cycles", cyc, TMO);
        @(negedge clk);
        chk("tmo_buserr", bus_err, 1);
        chk("tmo_rf_en", wb_rf_en, 0);
        edge1();
        dm_rvalid = 1'b1;
        @(negedge clk);
        chk("tmo_buserr_end", bus_err, 0);
        chk("tmo_idle", dm_req, 0);
        edge1();
        dm_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_ignored", wb_valid, 0);
        edge1();

        // Pipeline resumes after the abort
        e = mk(0, 0, 3'b010, 32'h55, 32'h0, 5'd12, 1'b1);
        exp_q.push_back(wbx(e, 32'd0, 1'b1));
        issue(e);
        @(negedge clk);
        chk("resume_ready", mem_ready, 1);
        edge1();

        // Reset while a load waits for rvalid: everything clears, nothing retires
        e = mk(1, 0, 3'b010, 32'h5000, 32'h0, 5'd13, 1'b1);
        issue(e);
        dm_gnt = 1'b1;
        edge1();
        dm_gnt = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        chk("arst_req", dm_req, 0);
        chk("arst_addr", dm_addr, 0);
        chk("arst_ready", mem_ready, 1);
        chk("arst_wbv", wb_valid, 0);
        chk("arst_wbres", wb_opr_res, 0);
        chk("arst_fwd", fwd_out, 0);
        @(negedge clk);
        #1 arst_n = 1'b1;
        edge1();
        dm_rvalid = 1'b1;
        @(negedge clk);
        chk("arst_noretire", wb_valid, 0);
        chk("arst_idle", dm_req, 0);
        edge1();
        dm_rvalid = 1'b0;
        @(negedge clk);
        chk("arst_late_ignored", wb_valid, 0);
        edge1();

        e = mk(0, 0, 3'b010, 32'h99, 32'h0, 5'd14, 1'b1);
        exp_q.push_back(wbx(e, 32'd0, 1'b1));
        issue(e);
        edge1();
        edge1();
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
